// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared word width, occupancy encodings and helpers for the drain
package fifo_drain_pkg;

    localparam int FIFO_WIDTH = 8;

    typedef enum logic [1:0] {
        FIFO_LVL_EMPTY = 2'd0,
        FIFO_LVL_ONE   = 2'd1,
        FIFO_LVL_FULL  = 2'd2
    } lvl_t;

    function automatic logic lvl_is_full(input lvl_t l);
        return l == FIFO_LVL_FULL;
    endfunction

endpackage

// File: rtl/fifo_drain_slot.sv
// fifo_drain_slot: one word register with an occupied bit, loaded or cleared on command
module fifo_drain_slot
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             occ
);

    // load wins over clear; the word is kept on clear so q holds its last value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q   <= '0;
            occ <= 1'b0;
        end else if (load) begin
            q   <= d;
            occ <= 1'b1;
        end else if (clear) begin
            occ <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: two-slot (head + skid) read-side terminator for the FIFO element chain
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_in_strobe,
    output logic             used,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    input  logic             rd_strobe,
    output logic [1:0]       level,
    output logic             overflow,
    output logic             underflow
);

    lvl_t             state, state_nx;
    logic             push, pop;
    logic             head_load, head_clear, skid_load, skid_clear;
    logic [WIDTH-1:0] head_d, skid_q;
    logic             head_occ, skid_occ;

    assign push  = d_in_strobe & ~used;
    assign pop   = rd_strobe & ~empty;
    assign used  = skid_occ;
    assign empty = ~head_occ;
    assign level = state;

    // occupancy register; reset discards everything held
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FIFO_LVL_EMPTY;
        else        state <= state_nx;
    end

    // a pop at level 1 paired with a push keeps the level; at level 2 the push was already refused
    always_comb begin
        state_nx = (state == FIFO_LVL_EMPTY) ? (push ? FIFO_LVL_ONE : FIFO_LVL_EMPTY) :
                   (state == FIFO_LVL_ONE)   ? ((push & ~pop) ? FIFO_LVL_FULL :
                                                (pop & ~push) ? FIFO_LVL_EMPTY : FIFO_LVL_ONE) :
                                               (pop ? FIFO_LVL_ONE : FIFO_LVL_FULL);
    end

    // slot controls: head takes d_in when empty or replaced, takes the skid word when draining from full
    always_comb begin
        head_load  = (push & ((state == FIFO_LVL_EMPTY) | (pop & (state == FIFO_LVL_ONE)))) |
                     (pop & lvl_is_full(state));
        head_d     = lvl_is_full(state) ? skid_q : d_in;
        head_clear = pop & ~push & (state == FIFO_LVL_ONE);
        skid_load  = push & ~pop & (state == FIFO_LVL_ONE);
        skid_clear = pop & lvl_is_full(state);
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (d_in_strobe & used);
            underflow <= underflow | (rd_strobe & empty);
        end
    end

    fifo_drain_slot #(.WIDTH(WIDTH)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .clear (head_clear),
        .d     (head_d),
        .q     (q),
        .occ   (head_occ)
    );

    fifo_drain_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (d_in),
        .q     (skid_q),
        .occ   (skid_occ)
    );

endmodule
